multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Parametrised multicycle RV32I sequencer: a registered FSM that steps each instruction through Fetch, Decode, Execute, Memory, Writeback and PC-update states. It drives the datapath control signals (PC, IR, ALU, register file, memory) and handshakes with a memory port that has variable latency. It also keeps retire and cycle counters. The block sits between the instruction register/decoder and the datapath, and replaces the single-state control unit.

## Interface
- `CNT_W`, 32: width of the `instret_count` and `cycle_count` counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `opcode` input 7: `instr[6:0]`, taken from the IR.
- `branch_taken` input 1: branch comparator result; sampled in EXECUTE.
- `mem_ready` input 1: memory accepts/completes the transfer; ignored while `mem_req`=0.
- `mem_req` output 1: memory transfer request.
- `mem_we` output 1: 1 = store, 0 = read.
- `mem_addr_sel` output 1: 0 = PC, 1 = ALU result.
- `ir_load` output 1: load the IR from memory read data.
- `pc_control` output 4: HOLD=0000, PLUS4=0001, BRANCH=0010, JAL=0011, JALR=0100, TRAP=1000.
- `alu_control` output 3: ADD=000, R_FUNCT=001, I_FUNCT=010, CMP=011, PASS_IMM=100, PC_IMM=101.
- `rf_we` output 1: register file write enable.
- `wb_sel` output 2: ALU=00, MEM=01, PC4=10.
- `trap` output 1: illegal-instruction pulse.
- `state` output 3: current state, for debug.
- `instret_count` output CNT_W: retired instruction count.
- `cycle_count` output CNT_W: cycles since reset.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, PC_UPDATE, TRAP.
- Encoding: `state` exposes the state code. Outputs are decoded combinationally from the state; `ir_load` also depends on `mem_ready`.
- Output defaults: every output is 0 and `pc_control`=HOLD unless a state below drives it.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr_sel`=0.
  - `mem_ready`=1: `ir_load`=1, go to DECODE.
  - `mem_ready`=0: stay in FETCH with the request held.
- DECODE: one cycle, then EXECUTE.
- EXECUTE:
  - Drives `alu_control` by opcode class: LOAD/STORE ADD; OP R_FUNCT; OP_IMM I_FUNCT; BRANCH CMP; LUI PASS_IMM; AUIPC and JAL PC_IMM; JALR ADD.
  - Next state:
    - LOAD/STORE go to MEM.
    - BRANCH goes to PC_UPDATE and latches `branch_taken` into a flag.
    - Every other legal class goes to WRITEBACK.
    - An illegal opcode follows the Configuration section.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(STORE).
  - On `mem_ready`: LOAD goes to WRITEBACK, STORE goes to PC_UPDATE.
  - Otherwise stay in MEM.
- WRITEBACK: `rf_we`=1; then FETCH.
  - `wb_sel`: MEM for LOAD, PC4 for JAL/JALR, ALU otherwise.
  - `pc_control`: JAL or JALR for jumps, PLUS4 otherwise.
- PC_UPDATE: then FETCH.
  - Branch: `pc_control`=BRANCH if the latched flag is set, else PLUS4.
  - Store and illegal-as-NOP: PLUS4.
- Counters:
  - `instret_count` increments in every cycle where `pc_control`≠HOLD and ≠TRAP.
  - `cycle_count` increments every cycle out of reset.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation:
  - State returns to FETCH immediately, counters clear, the branch flag clears.
  - Any outstanding memory request is abandoned; `mem_req` drops asynchronously.

## Timing
- While `rst_n`=0, all outputs are 0: `mem_req` is gated, `state` reads FETCH, counters are 0.
- First `mem_req`=1 appears in the first cycle after `rst_n` rises.
- Cycle counts with `mem_ready` tied high:
  - OP, OP_IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - BRANCH: 4 cycles.
  - LOAD and STORE: 5 cycles.
- Each cycle `mem_ready` stays low in FETCH or MEM adds exactly one cycle.
- Handshake: `mem_req`, `mem_we` and `mem_addr_sel` stay stable until the cycle in which `mem_ready`=1; the transfer completes in that cycle.
- `mem_ready`=1 while `mem_req`=0 has no effect.

## Configuration
- Macro: `MULTICYCLE_ILLEGAL_TRAP_EN`.
- Defined: an illegal opcode in EXECUTE goes to TRAP.
  - TRAP lasts one cycle, asserts `trap`=1 and `pc_control`=TRAP, then returns to FETCH.
  - `instret_count` is not incremented.
- Undefined: an illegal opcode is a NOP; EXECUTE goes to PC_UPDATE, which issues PLUS4.
  - `trap` is tied 0 and the TRAP state is not built.

## Structure
- Package `multicycle_pkg` holds:
  - the state enum;
  - the RV32I opcode constants (LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111);
  - the `pc_control`, `alu_control` and `wb_sel` encodings;
  - the opcode-class enum.
- Sub-module `opcode_classifier`: combinational, `opcode` to class plus an illegal flag.

## Test plan
- ADDI with `mem_ready` tied high: states FETCH→DECODE→EXECUTE→WRITEBACK; `rf_we`=1 and `pc_control`=0001 in cycle 4; `instret_count` 0→1.
- LW with `mem_ready` low for 3 cycles in MEM: 8 cycles total; `mem_addr_sel`=1 and `mem_we`=0 held stable during the wait; `wb_sel`=01.
- BEQ with `branch_taken`=1, then BNE with `branch_taken`=0: PC_UPDATE issues `pc_control`=0010, then 0001; `rf_we` never asserted.
- Opcode 0000000: with the macro defined, `trap`=1 for 1 cycle and `instret_count` unchanged; without it, PLUS4 and `instret_count`+1.
- `rst_n` pulsed low during a MEM wait: `mem_req` drops the same cycle; `state`=FETCH and counters 0; fetch restarts 1 cycle after release.
- `CNT_W`=4, 16 retired instructions: `instret_count` wraps to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types for the multicycle RV32I control FSM.
// State, opcode, control encodings and opcode classes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_PC_UPDATE = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    PC_HOLD   = 4'b0000,
    PC_PLUS4  = 4'b0001,
    PC_BRANCH = 4'b0010,
    PC_JAL    = 4'b0011,
    PC_JALR   = 4'b0100,
    PC_TRAP   = 4'b1000
  } pc_ctrl_e;

  typedef enum logic [2:0] {
    ALU_ADD      = 3'b000,
    ALU_R_FUNCT  = 3'b001,
    ALU_I_FUNCT  = 3'b010,
    ALU_CMP      = 3'b011,
    ALU_PASS_IMM = 3'b100,
    ALU_PC_IMM   = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_OP_IMM,
    CLS_OP,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_NONE
  } op_class_e;

  typedef struct packed {
    logic      mem_req;
    logic      mem_we;
    logic      mem_addr_sel;
    logic      ir_load;
    pc_ctrl_e  pc_control;
    alu_ctrl_e alu_control;
    logic      rf_we;
    wb_sel_e   wb_sel;
    logic      trap;
  } ctrl_t;

  function automatic logic retires(input pc_ctrl_e pc);
    return (pc != PC_HOLD) && (pc != PC_TRAP);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_opcode_classifier.sv
// Combinational RV32I opcode classifier.
// Unknown opcodes map to CLS_NONE with illegal set.
module opcode_classifier
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CLS_NONE;
    illegal  = 1'b0;
    unique case (1'b1)
      (opcode == OPC_LOAD):   op_class = CLS_LOAD;
      (opcode == OPC_STORE):  op_class = CLS_STORE;
      (opcode == OPC_OP_IMM): op_class = CLS_OP_IMM;
      (opcode == OPC_OP):     op_class = CLS_OP;
      (opcode == OPC_BRANCH): op_class = CLS_BRANCH;
      (opcode == OPC_JAL):    op_class = CLS_JAL;
      (opcode == OPC_JALR):   op_class = CLS_JALR;
      (opcode == OPC_LUI):    op_class = CLS_LUI;
      (opcode == OPC_AUIPC):  op_class = CLS_AUIPC;
      default:                illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer with retire/cycle counters.
// MULTICYCLE_ILLEGAL_TRAP_EN: illegal opcodes trap instead of NOP.
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic [3:0]       pc_control,
  output logic [2:0]       alu_control,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_e    state_q, state_d;
  logic      br_q, br_d;
  op_class_e op_class;
  logic      illegal;
  ctrl_t     ctrl, ctrl_out;

  opcode_classifier u_cls (
    .opcode   (opcode),
    .op_class (op_class),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      br_q          <= 1'b0;
      instret_count <= '0;
      cycle_count   <= '0;
    end else begin
      state_q     <= state_d;
      br_q        <= br_d;
      cycle_count <= cycle_count + CNT_W'(1);
      if (retires(ctrl.pc_control))
        instret_count <= instret_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    br_d             = br_q;
    ctrl             = '0;
    ctrl.pc_control  = PC_HOLD;
    ctrl.alu_control = ALU_ADD;
    ctrl.wb_sel      = WB_ALU;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_load = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        unique case (op_class)
          CLS_OP:     ctrl.alu_control = ALU_R_FUNCT;
          CLS_OP_IMM: ctrl.alu_control = ALU_I_FUNCT;
          CLS_BRANCH: ctrl.alu_control = ALU_CMP;
          CLS_LUI:    ctrl.alu_control = ALU_PASS_IMM;
          CLS_AUIPC,
          CLS_JAL:    ctrl.alu_control = ALU_PC_IMM;
          default:    ctrl.alu_control = ALU_ADD;
        endcase
        if (illegal) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_PC_UPDATE;
`endif
        end else if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
          state_d = S_MEM;
        end else if (op_class == CLS_BRANCH) begin
          br_d    = branch_taken;
          state_d = S_PC_UPDATE;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_we       = (op_class == CLS_STORE);
        if (mem_ready)
          state_d = (op_class == CLS_LOAD) ? S_WRITEBACK : S_PC_UPDATE;
      end
      S_WRITEBACK: begin
        ctrl.rf_we = 1'b1;
        unique case (op_class)
          CLS_LOAD: begin
            ctrl.wb_sel     = WB_MEM;
            ctrl.pc_control = PC_PLUS4;
          end
          CLS_JAL: begin
            ctrl.wb_sel     = WB_PC4;
            ctrl.pc_control = PC_JAL;
          end
          CLS_JALR: begin
            ctrl.wb_sel     = WB_PC4;
            ctrl.pc_control = PC_JALR;
          end
          default: ctrl.pc_control = PC_PLUS4;
        endcase
        state_d = S_FETCH;
      end
      S_PC_UPDATE: begin
        ctrl.pc_control = (op_class == CLS_BRANCH && br_q) ?
                          PC_BRANCH : PC_PLUS4;
        state_d = S_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.trap       = 1'b1;
        ctrl.pc_control = PC_TRAP;
        state_d         = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every output so an in-flight request drops at once.
  assign ctrl_out     = rst_n ? ctrl : '0;
  assign mem_req      = ctrl_out.mem_req;
  assign mem_we       = ctrl_out.mem_we;
  assign mem_addr_sel = ctrl_out.mem_addr_sel;
  assign ir_load      = ctrl_out.ir_load;
  assign pc_control   = ctrl_out.pc_control;
  assign alu_control  = ctrl_out.alu_control;
  assign rf_we        = ctrl_out.rf_we;
  assign wb_sel       = ctrl_out.wb_sel;
  assign trap         = ctrl_out.trap;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
// A CNT_W=4 twin shares the stimulus to exercise counter wrap.
module tb_multicycle_control_fsm;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3;
  localparam logic [2:0] SW = 3'd4, SP = 3'd5, ST = 3'd6;

  logic        clk, rst_n, branch_taken, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, rf_we, trap;
  logic [3:0]  pc_control;
  logic [2:0]  alu_control, state;
  logic [1:0]  wb_sel;
  logic [31:0] instret_count, cycle_count;

  logic        s_mem_req, s_mem_we, s_mem_addr_sel, s_ir_load;
  logic        s_rf_we, s_trap;
  logic [3:0]  s_pc_control;
  logic [2:0]  s_alu_control, s_state;
  logic [1:0]  s_wb_sel;
  logic [3:0]  s_instret, s_cycle;

  int          errs, checks;
  int          exp_ret;
  logic [31:0] exp_cyc;

  multicycle_control_fsm #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_control(pc_control),
    .alu_control(alu_control), .rf_we(rf_we), .wb_sel(wb_sel),
    .trap(trap), .state(state), .instret_count(instret_count),
    .cycle_count(cycle_count)
  );

  multicycle_control_fsm #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_addr_sel(s_mem_addr_sel), .ir_load(s_ir_load),
    .pc_control(s_pc_control), .alu_control(s_alu_control),
    .rf_we(s_rf_we), .wb_sel(s_wb_sel), .trap(s_trap),
    .state(s_state), .instret_count(s_instret),
    .cycle_count(s_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_cyc <= '0;
    else        exp_cyc <= exp_cyc + 32'd1;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== SF) begin
      errs++; $display("FAIL reset_state got=%0d exp=%0d", state, SF);
    end
    checks++;
    if (mem_req !== 1'b0 || ir_load !== 1'b0) begin
      errs++; $display("FAIL reset_gate req=%b ir=%b exp=0", mem_req, ir_load);
    end
    checks++;
    if (instret_count !== 32'd0 || cycle_count !== 32'd0) begin
      errs++;
      $display("FAIL reset_cnt ret=%0d cyc=%0d exp=0", instret_count, cycle_count);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || state !== SF) begin
      errs++; $display("FAIL first_req req=%b st=%0d exp=1/0", mem_req, state);
    end
  endtask

  task automatic test_addi();
    opcode = 7'b0010011; mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== SF || ir_load !== 1'b1) begin
      errs++; $display("FAIL addi_fetch st=%0d ir=%b exp=0/1", state, ir_load);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== SD || mem_req !== 1'b0) begin
      errs++; $display("FAIL addi_decode st=%0d req=%b exp=1/0", state, mem_req);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== SE || alu_control !== 3'b010) begin
      errs++; $display("FAIL addi_exec st=%0d alu=%b exp=2/010", state, alu_control);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== SW || rf_we !== 1'b1 || pc_control !== 4'b0001 ||
        wb_sel !== 2'b00 || instret_count !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL addi_wb st=%0d we=%b pc=%b wb=%b ret=%0d exp=4/1/0001/00/%0d",
               state, rf_we, pc_control, wb_sel, instret_count, exp_ret);
    end
    exp_ret++;
    @(negedge clk); #1;
    checks++;
    if (state !== SF || instret_count !== 32'(exp_ret) ||
        cycle_count !== exp_cyc) begin
      errs++;
      $display("FAIL addi_retire st=%0d ret=%0d cyc=%0d exp=0/%0d/%0d",
               state, instret_count, cycle_count, exp_ret, exp_cyc);
    end
  endtask

  task automatic test_lw_wait();
    opcode = 7'b0000011; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (state !== SE || alu_control !== 3'b000) begin
      errs++; $display("FAIL lw_exec st=%0d alu=%b exp=2/000", state, alu_control);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state !== SM || mem_req !== 1'b1 || mem_addr_sel !== 1'b1 ||
          mem_we !== 1'b0) begin
        errs++;
        $display("FAIL lw_wait%0d st=%0d req=%b sel=%b we=%b exp=3/1/1/0",
                 i, state, mem_req, mem_addr_sel, mem_we);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== SM || mem_addr_sel !== 1'b1) begin
      errs++; $display("FAIL lw_done st=%0d sel=%b exp=3/1", state, mem_addr_sel);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== SW || wb_sel !== 2'b01 || rf_we !== 1'b1) begin
      errs++; $display("FAIL lw_wb st=%0d wb=%b we=%b exp=4/01/1", state, wb_sel, rf_we);
    end
    exp_ret++;
    @(negedge clk); #1;
    checks++;
    if (state !== SF || instret_count !== 32'(exp_ret) ||
        cycle_count !== exp_cyc) begin
      errs++;
      $display("FAIL lw_retire st=%0d ret=%0d cyc=%0d exp=0/%0d/%0d",
               state, instret_count, cycle_count, exp_ret, exp_cyc);
    end
  endtask

  task automatic test_sw_fetch_wait();
    opcode = 7'b0100011; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (state !== SF || mem_req !== 1'b1 || mem_addr_sel !== 1'b0 ||
          ir_load !== 1'b0) begin
        errs++;
        $display("FAIL sw_fwait%0d st=%0d req=%b sel=%b ir=%b exp=0/1/0/0",
                 i, state, mem_req, mem_addr_sel, ir_load);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== SF || ir_load !== 1'b1) begin
      errs++; $display("FAIL sw_fetch st=%0d ir=%b exp=0/1", state, ir_load);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== SM || mem_we !== 1'b1 || mem_addr_sel !== 1'b1) begin
      errs++; $display("FAIL sw_mem st=%0d we=%b sel=%b exp=3/1/1", state, mem_we, mem_addr_sel);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== SP || pc_control !== 4'b0001 || rf_we !== 1'b0) begin
      errs++; $display("FAIL sw_pcu st=%0d pc=%b we=%b exp=5/0001/0", state, pc_control, rf_we);
    end
    exp_ret++;
    @(negedge clk); #1;
    checks++;
    if (instret_count !== 32'(exp_ret)) begin
      errs++; $display("FAIL sw_retire ret=%0d exp=%0d", instret_count, exp_ret);
    end
  endtask

  task automatic test_branch();
    logic [3:0] exp_pc;
    for (int t = 0; t < 2; t++) begin
      exp_pc = (t == 0) ? 4'b0010 : 4'b0001;
      opcode = 7'b1100011; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      branch_taken = (t == 0);
      #1;
      checks++;
      if (state !== SE || alu_control !== 3'b011 || rf_we !== 1'b0) begin
        errs++;
        $display("FAIL br%0d_exec st=%0d alu=%b we=%b exp=2/011/0",
                 t, state, alu_control, rf_we);
      end
      @(negedge clk);
      branch_taken = (t != 0);
      #1;
      checks++;
      if (state !== SP || pc_control !== exp_pc || rf_we !== 1'b0) begin
        errs++;
        $display("FAIL br%0d_pcu st=%0d pc=%b we=%b exp=5/%b/0",
                 t, state, pc_control, rf_we, exp_pc);
      end
      branch_taken = 1'b0;
      exp_ret++;
      @(negedge clk); #1;
      checks++;
      if (state !== SF || instret_count !== 32'(exp_ret)) begin
        errs++;
        $display("FAIL br%0d_retire st=%0d ret=%0d exp=0/%0d",
                 t, state, instret_count, exp_ret);
      end
    end
  endtask

  task automatic test_jumps();
    logic [6:0] ops [5];
    logic [2:0] alus [5];
    logic [1:0] wbs [5];
    logic [3:0] pcs [5];
    ops  = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0110011, 7'b0010111};
    alus = '{3'b101, 3'b000, 3'b100, 3'b001, 3'b101};
    wbs  = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    pcs  = '{4'b0011, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k]; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if (state !== SE || alu_control !== alus[k]) begin
        errs++;
        $display("FAIL op%0d_exec st=%0d alu=%b exp=2/%b", k, state, alu_control, alus[k]);
      end
      @(negedge clk); #1;
      checks++;
      if (state !== SW || wb_sel !== wbs[k] || pc_control !== pcs[k] ||
          rf_we !== 1'b1) begin
        errs++;
        $display("FAIL op%0d_wb st=%0d wb=%b pc=%b we=%b exp=4/%b/%b/1",
                 k, state, wb_sel, pc_control, rf_we, wbs[k], pcs[k]);
      end
      exp_ret++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (instret_count !== 32'(exp_ret) || cycle_count !== exp_cyc) begin
      errs++;
      $display("FAIL jumps_cnt ret=%0d cyc=%0d exp=%0d/%0d",
               instret_count, cycle_count, exp_ret, exp_cyc);
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    checks++;
    if (state !== ST || trap !== 1'b1 || pc_control !== 4'b1000) begin
      errs++;
      $display("FAIL ill_trap st=%0d trap=%b pc=%b exp=6/1/1000", state, trap, pc_control);
    end
`else
    checks++;
    if (state !== SP || trap !== 1'b0 || pc_control !== 4'b0001) begin
      errs++;
      $display("FAIL ill_nop st=%0d trap=%b pc=%b exp=5/0/0001", state, trap, pc_control);
    end
    exp_ret++;
`endif
    @(negedge clk); #1;
    checks++;
    if (state !== SF || trap !== 1'b0 || instret_count !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL ill_after st=%0d trap=%b ret=%0d exp=0/0/%0d",
               state, trap, instret_count, exp_ret);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 7'b0000011; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || state !== SF) begin
      errs++; $display("FAIL rstmid_drop req=%b st=%0d exp=0/0", mem_req, state);
    end
    checks++;
    if (instret_count !== 32'd0 || cycle_count !== 32'd0 || s_instret !== 4'd0) begin
      errs++;
      $display("FAIL rstmid_cnt ret=%0d cyc=%0d sret=%0d exp=0",
               instret_count, cycle_count, s_instret);
    end
    exp_ret = 0;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errs++; $display("FAIL rstmid_ready req=%b exp=0", mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== SF || mem_req !== 1'b1 || ir_load !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_fetch st=%0d req=%b ir=%b exp=0/1/1", state, mem_req, ir_load);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== SD) begin
      errs++; $display("FAIL rstmid_decode st=%0d exp=1", state);
    end
    repeat (3) @(negedge clk);
    exp_ret++;
    @(negedge clk); #1;
    checks++;
    if (instret_count !== 32'(exp_ret) || cycle_count !== 32'd5) begin
      errs++;
      $display("FAIL rstmid_lw ret=%0d cyc=%0d exp=%0d/5", instret_count, cycle_count, exp_ret);
    end
  endtask

  task automatic test_wrap();
    opcode = 7'b0010011; mem_ready = 1'b1;
    while (exp_ret < 15) begin
      repeat (4) @(negedge clk);
      exp_ret++;
    end
    #1;
    checks++;
    if (s_instret !== 4'hf) begin
      errs++; $display("FAIL wrap_15 sret=%0d exp=15", s_instret);
    end
    repeat (4) @(negedge clk);
    exp_ret++;
    #1;
    checks++;
    if (s_instret !== 4'd0 || instret_count !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL wrap_16 sret=%0d ret=%0d exp=0/%0d", s_instret, instret_count, exp_ret);
    end
    checks++;
    if (s_cycle !== exp_cyc[3:0]) begin
      errs++; $display("FAIL wrap_cyc scyc=%0d exp=%0d", s_cycle, exp_cyc[3:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0;
    errs = 0; checks = 0; exp_ret = 0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
